// File: rtl/mem_arb_pkg.sv
// Shared types for the IF/LSU memory-port arbiter.
package mem_arb_pkg;
  localparam int ARB_DATA_W = 64;
  localparam int WMASK_W    = ARB_DATA_W / 8;

  typedef enum logic [1:0] {ARB_IDLE, ARB_REQ, ARB_RESP} arb_state_t;
  typedef enum logic {OWN_IF, OWN_LSU} arb_owner_t;
endpackage

// File: rtl/mem_arb_sel.sv
// Grant select between IF and LSU. MEM_ARB_RR_EN selects round-robin,
// otherwise LSU has fixed priority over IF.
module mem_arb_sel
  import mem_arb_pkg::*;
(
  input  logic       if_valid,
  input  logic       lsu_valid,
  input  arb_owner_t last_owner,
  output logic       gnt_if,
  output logic       gnt_lsu
);
`ifdef MEM_ARB_RR_EN
  always_comb begin
    gnt_lsu = lsu_valid;
    // On contention hand the port to whoever was not served last
    if (if_valid && lsu_valid) gnt_lsu = (last_owner == OWN_IF);
    gnt_if = if_valid && !gnt_lsu;
  end
`else
  logic unused_owner;
  assign unused_owner = last_owner;

  always_comb begin
    gnt_lsu = lsu_valid;
    gnt_if  = if_valid && !gnt_lsu;
  end
`endif
endmodule

// File: rtl/mem_arbiter.sv
// Shares one 64-bit memory port between IF (read-only) and LSU, one transaction
// in flight. Build with MEM_ARB_RR_EN for round-robin arbitration.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int INST_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_req_valid,
  output logic               if_req_ready,
  input  logic [ADDR_W-1:0]  if_addr,
  output logic               if_resp_valid,
  output logic [INST_W-1:0]  if_inst,
  input  logic               lsu_req_valid,
  output logic               lsu_req_ready,
  input  logic               lsu_wen,
  input  logic [ADDR_W-1:0]  lsu_addr,
  input  logic [DATA_W-1:0]  lsu_wdata,
  input  logic [WMASK_W-1:0] lsu_wmask,
  output logic               lsu_resp_valid,
  output logic [DATA_W-1:0]  lsu_rdata,
  output logic               mem_req_valid,
  input  logic               mem_req_ready,
  output logic               mem_wen,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  output logic [WMASK_W-1:0] mem_wmask,
  input  logic               mem_resp_valid,
  input  logic [DATA_W-1:0]  mem_rdata
);
  typedef struct packed {
    arb_owner_t          owner;
    logic                wen;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   wdata;
    logic [WMASK_W-1:0]  wmask;
  } arb_req_t;

  arb_state_t state, state_nxt;
  arb_req_t   req_d, req_q;
  logic       gnt_if, gnt_lsu, accept, resp_fire;

  mem_arb_sel u_sel (
    .if_valid   (if_req_valid),
    .lsu_valid  (lsu_req_valid),
    .last_owner (req_q.owner),
    .gnt_if     (gnt_if),
    .gnt_lsu    (gnt_lsu)
  );

  // Ready is masked by rst so every output reads 0 while reset is held
  assign if_req_ready  = (state == ARB_IDLE) && gnt_if  && !rst;
  assign lsu_req_ready = (state == ARB_IDLE) && gnt_lsu && !rst;
  assign accept        = if_req_ready || lsu_req_ready;
  assign resp_fire     = (state == ARB_RESP) && mem_resp_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ARB_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    mem_req_valid = 1'b0;
    case (state)
      ARB_IDLE: if (accept) state_nxt = ARB_REQ;
      ARB_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_nxt = ARB_RESP;
      end
      ARB_RESP: if (mem_resp_valid) state_nxt = ARB_IDLE;
      default:  state_nxt = ARB_IDLE;
    endcase
  end

  always_comb begin
    req_d = '0;
    if (gnt_lsu) begin
      req_d.owner = OWN_LSU;
      req_d.wen   = lsu_wen;
      req_d.addr  = lsu_addr;
      req_d.wdata = lsu_wdata;
      req_d.wmask = lsu_wmask;
    end else begin
      req_d.owner = OWN_IF;
      req_d.addr  = if_addr;
    end
  end

  // req_q.owner doubles as the last-grant record for round-robin
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         req_q <= '0;
    else if (accept) req_q <= req_d;
  end

  assign mem_wen   = req_q.wen;
  assign mem_addr  = req_q.addr;
  assign mem_wdata = req_q.wdata;
  assign mem_wmask = req_q.wmask;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_resp_valid  <= 1'b0;
      if_inst        <= '0;
      lsu_resp_valid <= 1'b0;
      lsu_rdata      <= '0;
    end else begin
      if_resp_valid  <= 1'b0;
      lsu_resp_valid <= 1'b0;
      if (resp_fire) begin
        if (req_q.owner == OWN_IF) begin
          if_resp_valid <= 1'b1;
          if_inst       <= req_q.addr[2] ? mem_rdata[DATA_W-1 -: INST_W] : mem_rdata[INST_W-1:0];
        end else begin
          lsu_resp_valid <= 1'b1;
          if (!req_q.wen) lsu_rdata <= mem_rdata;
        end
      end
    end
  end
endmodule
